// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial byte-stream program loader for the instruction memory
module prog_loader #(
    parameter int INST_WIDTH     = 32,
    parameter int INST_MEM_WIDTH = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [INST_WIDTH-1:0]     inst_word,
    output logic                      we,
    output logic                      reset_pc,
    output logic                      stall,
    output logic                      running,
    output logic                      error,
    output logic [INST_MEM_WIDTH:0]   load_count
);

    localparam int              BYTES     = INST_WIDTH / 8;
    localparam logic [7:0]      LAST_BYTE = 8'(BYTES - 1);
    localparam logic [32:0]     CAPACITY  = 33'(1) << INST_MEM_WIDTH;

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_WRITE,
        S_REWIND,
        S_RUN,
        S_ERR
    } state_t;

    state_t                   state;
    state_t                   state_nx;
    logic [7:0]               byte_cnt;
    logic [7:0]               byte_cnt_nx;
    logic [31:0]              hdr_q;
    logic [31:0]              hdr_nx;
    logic [INST_WIDTH-1:0]    word_nx;
    logic [INST_MEM_WIDTH:0]  count_nx;

    // Big-endian assembly: each new byte shifts in at the bottom, so the first
    // byte of a word ends up in the top byte lane once the word is complete.
    logic [31:0]              hdr_shift;
    logic [INST_WIDTH-1:0]    word_shift;
    logic                     count_done;

    assign hdr_shift  = {hdr_q[23:0], rx_data};
    assign word_shift = INST_WIDTH'({inst_word, rx_data});
    assign count_done = (32'(load_count) + 32'd1) == hdr_q;

    // Next-state, byte assembly and word-count decode
    always_comb begin
        state_nx    = state;
        byte_cnt_nx = byte_cnt;
        hdr_nx      = hdr_q;
        word_nx     = inst_word;
        count_nx    = load_count;
        case (state)
            S_HDR: begin
                if (rx_valid) begin
                    hdr_nx = hdr_shift;
                    if (byte_cnt == 8'd3) begin
                        byte_cnt_nx = 8'd0;
                        if (hdr_shift == 32'd0)
                            state_nx = S_REWIND;
                        else if ({1'b0, hdr_shift} > CAPACITY)
                            state_nx = S_ERR;
                        else
                            state_nx = S_LOAD;
                    end else begin
                        byte_cnt_nx = byte_cnt + 8'd1;
                    end
                end
            end
            S_LOAD: begin
                if (rx_valid) begin
                    word_nx = word_shift;
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt_nx = 8'd0;
                        state_nx    = S_WRITE;
                    end else begin
                        byte_cnt_nx = byte_cnt + 8'd1;
                    end
                end
            end
            S_WRITE: begin
                count_nx = load_count + 1'b1;
                if (count_done) begin
                    byte_cnt_nx = 8'd0;
                    state_nx    = S_REWIND;
                end else if (rx_valid) begin
                    // A byte landing during the write is the next word's first byte.
                    word_nx = word_shift;
                    if (LAST_BYTE == 8'd0) begin
                        byte_cnt_nx = 8'd0;
                        state_nx    = S_WRITE;
                    end else begin
                        byte_cnt_nx = 8'd1;
                        state_nx    = S_LOAD;
                    end
                end else begin
                    byte_cnt_nx = 8'd0;
                    state_nx    = S_LOAD;
                end
            end
            S_REWIND: begin
                byte_cnt_nx = 8'd0;
                state_nx    = S_RUN;
            end
            S_RUN:   state_nx = S_RUN;
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_HDR;
        endcase
    end

    // State, datapath and outputs registered from the next state so no rx path reaches a port
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_HDR;
            byte_cnt   <= 8'd0;
            hdr_q      <= 32'd0;
            inst_word  <= '0;
            load_count <= '0;
            we         <= 1'b0;
            reset_pc   <= 1'b1;
            stall      <= 1'b1;
            running    <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nx;
            byte_cnt   <= byte_cnt_nx;
            hdr_q      <= hdr_nx;
            inst_word  <= word_nx;
            load_count <= count_nx;
            we         <= (state_nx == S_WRITE);
            reset_pc   <= (state_nx == S_REWIND);
            stall      <= !((state_nx == S_WRITE) || (state_nx == S_RUN));
            running    <= (state_nx == S_RUN);
            error      <= (state_nx == S_ERR);
        end
    end

endmodule
